// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: coin-operated vending controller with half-unit credit, change return and reject handling.
// Define VEND_STOCK_EN to enable the stock counter, sold_out and restock.
module vend_ctrl_param #(
    parameter int PRICE      = 5,
    parameter int CREDIT_W   = 5,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                coin_half,
    input  logic                coin_one,
    input  logic                cancel,
    input  logic                restock,
    output logic                dispense,
    output logic                change_half,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                sold_out
);
`ifdef VEND_STOCK_EN
    localparam bit STOCK_EN = 1'b1;
`else
    localparam bit STOCK_EN = 1'b0;
`endif
    localparam logic [CREDIT_W+1:0] MAX_C   = (CREDIT_W+2)'((1 << CREDIT_W) - 1);
    localparam logic [CREDIT_W+1:0] PRICE_S = (CREDIT_W+2)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [STOCK_W-1:0]  STOCK_R = STOCK_W'(STOCK_INIT);

    typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

    state_t              state, state_nx;
    logic [CREDIT_W-1:0] credit_nx;
    logic [STOCK_W-1:0]  stock, stock_nx;
    logic [CREDIT_W+1:0] sum;
    logic [1:0]          value;
    logic                coin, cancel_ok, accept, empty;
    logic                dispense_nx, change_nx, reject_nx;

    assign busy     = state != IDLE;
    assign sold_out = empty;

    always_comb begin
        value       = {coin_one, 1'b0} + {1'b0, coin_half};
        coin        = coin_one | coin_half;
        sum         = {2'b00, credit} + {{CREDIT_W{1'b0}}, value};
        empty       = STOCK_EN && stock == '0;
        // cancel only takes effect with credit to refund, and then beats any coin
        cancel_ok   = state == IDLE && cancel && credit != '0;
        accept      = state == IDLE && coin && !cancel_ok && !empty && sum <= MAX_C;
        state_nx    = state;
        credit_nx   = credit;
        stock_nx    = stock;
        dispense_nx = 1'b0;
        change_nx   = 1'b0;
        reject_nx   = coin && !accept;
        case (state)
            IDLE: begin
                if (cancel_ok)
                    state_nx = CHANGE;
                else if (accept) begin
                    credit_nx = sum[CREDIT_W-1:0];
                    state_nx  = sum >= PRICE_S ? VEND : IDLE;
                end
                if (STOCK_EN && restock)
                    stock_nx = STOCK_R;
            end
            VEND: begin
                dispense_nx = 1'b1;
                credit_nx   = credit - PRICE_C;
                state_nx    = credit != PRICE_C ? CHANGE : IDLE;
                stock_nx    = stock != '0 ? stock - 1'b1 : stock;
            end
            CHANGE: begin
                change_nx = 1'b1;
                credit_nx = credit - 1'b1;
                state_nx  = credit == CREDIT_W'(1) ? IDLE : CHANGE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            credit      <= '0;
            stock       <= STOCK_R;
            dispense    <= 1'b0;
            change_half <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_nx;
            credit      <= credit_nx;
            stock       <= stock_nx;
            dispense    <= dispense_nx;
            change_half <= change_nx;
            coin_reject <= reject_nx;
        end
    end
endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb_vend_ctrl_param: directed self-checking bench; u_dut uses defaults, u_small is a 3-bit credit, PRICE=7, STOCK_INIT=1 variant.
module tb_vend_ctrl_param;
    logic       sys_clk = 1'b0, sys_rst_n = 1'b0;
    logic       coin_half = 1'b0, coin_one = 1'b0, cancel = 1'b0, restock = 1'b0;
    logic       dispense, change_half, coin_reject, busy, sold_out;
    logic [4:0] credit;
    logic       s_dispense, s_change_half, s_coin_reject, s_busy, s_sold_out;
    logic [2:0] s_credit;
    int         checks = 0, failures = 0;

    always #5 sys_clk = ~sys_clk;

    vend_ctrl_param u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .coin_half(coin_half), .coin_one(coin_one),
        .cancel(cancel), .restock(restock), .dispense(dispense), .change_half(change_half),
        .coin_reject(coin_reject), .credit(credit), .busy(busy), .sold_out(sold_out)
    );

    vend_ctrl_param #(.PRICE(7), .CREDIT_W(3), .STOCK_W(2), .STOCK_INIT(1)) u_small (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .coin_half(coin_half), .coin_one(coin_one),
        .cancel(cancel), .restock(restock), .dispense(s_dispense), .change_half(s_change_half),
        .coin_reject(s_coin_reject), .credit(s_credit), .busy(s_busy), .sold_out(s_sold_out)
    );

    task automatic drive(input logic h, input logic o, input logic c, input logic r);
        coin_half = h; coin_one = o; cancel = c; restock = r;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        sys_rst_n = 1'b0;
        #3 sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2;
        checks++; if ({dispense, change_half, coin_reject, busy, credit} !== 9'b0) begin failures++; $display("FAIL reset_outputs got=%b want=0", {dispense, change_half, coin_reject, busy, credit}); end
        checks++; if (sold_out !== 1'b0) begin failures++; $display("FAIL reset_sold_out got=%b want=0", sold_out); end
        #4 sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_exact_vend();
        do_reset();
        drive(0, 1, 0, 0); tick();
        checks++; if (credit !== 5'd2) begin failures++; $display("FAIL exact_credit1 got=%0d want=2", credit); end
        tick();
        checks++; if (credit !== 5'd4 || busy !== 1'b0) begin failures++; $display("FAIL exact_credit2 got=%0d/%b want=4/0", credit, busy); end
        drive(1, 0, 0, 0); tick();
        checks++; if (credit !== 5'd5 || busy !== 1'b1 || dispense !== 1'b0) begin failures++; $display("FAIL exact_enter_vend got=%0d/%b/%b want=5/1/0", credit, busy, dispense); end
        drive(0, 0, 0, 0); tick();
        checks++; if (dispense !== 1'b1 || credit !== 5'd0 || busy !== 1'b0) begin failures++; $display("FAIL exact_dispense got=%b/%0d/%b want=1/0/0", dispense, credit, busy); end
        tick();
        checks++; if (dispense !== 1'b0 || change_half !== 1'b0) begin failures++; $display("FAIL exact_after got=%b/%b want=0/0", dispense, change_half); end
    endtask

    task automatic test_vend_change();
        do_reset();
        drive(0, 1, 0, 0); tick(); tick(); tick();
        checks++; if (credit !== 5'd6 || busy !== 1'b1) begin failures++; $display("FAIL change_enter got=%0d/%b want=6/1", credit, busy); end
        drive(0, 0, 0, 0); tick();
        checks++; if (dispense !== 1'b1 || credit !== 5'd1 || change_half !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL change_dispense got=%b/%0d/%b/%b want=1/1/0/1", dispense, credit, change_half, busy); end
        tick();
        checks++; if (change_half !== 1'b1 || dispense !== 1'b0 || credit !== 5'd0 || busy !== 1'b0) begin failures++; $display("FAIL change_pulse got=%b/%b/%0d/%b want=1/0/0/0", change_half, dispense, credit, busy); end
        tick();
        checks++; if (change_half !== 1'b0) begin failures++; $display("FAIL change_end got=%b want=0", change_half); end
    endtask

    task automatic test_cancel();
        do_reset();
        drive(0, 0, 1, 0); tick();
        checks++; if (busy !== 1'b0 || change_half !== 1'b0) begin failures++; $display("FAIL cancel_zero got=%b/%b want=0/0", busy, change_half); end
        drive(0, 1, 0, 0); tick();
        drive(1, 0, 0, 0); tick();
        drive(0, 0, 1, 0); tick();
        checks++; if (busy !== 1'b1 || change_half !== 1'b0 || credit !== 5'd3) begin failures++; $display("FAIL cancel_start got=%b/%b/%0d want=1/0/3", busy, change_half, credit); end
        drive(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (change_half !== 1'b1 || dispense !== 1'b0 || credit !== 5'(2 - i) || busy !== (i < 2)) begin failures++; $display("FAIL cancel_refund%0d got=%b/%b/%0d/%b want=1/0/%0d/%b", i, change_half, dispense, credit, busy, 2 - i, i < 2); end
        end
        tick();
        checks++; if (change_half !== 1'b0) begin failures++; $display("FAIL cancel_end got=%b want=0", change_half); end
    endtask

    task automatic test_reject_busy();
        do_reset();
        drive(1, 1, 0, 0); tick();
        checks++; if (credit !== 5'd3 || coin_reject !== 1'b0) begin failures++; $display("FAIL both_coins got=%0d/%b want=3/0", credit, coin_reject); end
        tick();
        drive(0, 0, 1, 0); tick();
        checks++; if (dispense !== 1'b1 || credit !== 5'd1) begin failures++; $display("FAIL vend_ignore_cancel got=%b/%0d want=1/1", dispense, credit); end
        drive(0, 1, 0, 0); tick();
        checks++; if (coin_reject !== 1'b1 || change_half !== 1'b1 || credit !== 5'd0) begin failures++; $display("FAIL change_coin_reject got=%b/%b/%0d want=1/1/0", coin_reject, change_half, credit); end
        drive(0, 0, 0, 0); tick();
        checks++; if (coin_reject !== 1'b0 || credit !== 5'd0) begin failures++; $display("FAIL reject_pulse_end got=%b/%0d want=0/0", coin_reject, credit); end
    endtask

    task automatic test_cancel_wins();
        do_reset();
        drive(0, 1, 0, 0); tick();
        drive(1, 0, 1, 0); tick();
        checks++; if (coin_reject !== 1'b1 || credit !== 5'd2 || busy !== 1'b1) begin failures++; $display("FAIL cancel_wins got=%b/%0d/%b want=1/2/1", coin_reject, credit, busy); end
        drive(0, 0, 0, 0); tick(); tick();
        checks++; if (credit !== 5'd0 || busy !== 1'b0 || dispense !== 1'b0) begin failures++; $display("FAIL cancel_wins_done got=%0d/%b/%b want=0/0/0", credit, busy, dispense); end
    endtask

    task automatic test_overflow_stock();
        do_reset();
        drive(0, 1, 0, 0); tick(); tick(); tick();
        checks++; if (s_credit !== 3'd6 || s_busy !== 1'b0) begin failures++; $display("FAIL small_credit got=%0d/%b want=6/0", s_credit, s_busy); end
        tick();
        checks++; if (s_coin_reject !== 1'b1 || s_credit !== 3'd6) begin failures++; $display("FAIL overflow_reject got=%b/%0d want=1/6", s_coin_reject, s_credit); end
        drive(1, 0, 0, 0); tick();
        checks++; if (s_credit !== 3'd7 || s_busy !== 1'b1 || s_coin_reject !== 1'b0) begin failures++; $display("FAIL max_credit got=%0d/%b/%b want=7/1/0", s_credit, s_busy, s_coin_reject); end
        drive(0, 0, 0, 0); tick();
        checks++; if (s_dispense !== 1'b1 || s_credit !== 3'd0) begin failures++; $display("FAIL small_vend got=%b/%0d want=1/0", s_dispense, s_credit); end
`ifdef VEND_STOCK_EN
        checks++; if (s_sold_out !== 1'b1) begin failures++; $display("FAIL sold_out got=%b want=1", s_sold_out); end
        drive(0, 1, 0, 0); tick();
        checks++; if (s_coin_reject !== 1'b1 || s_credit !== 3'd0) begin failures++; $display("FAIL sold_out_reject got=%b/%0d want=1/0", s_coin_reject, s_credit); end
        drive(0, 0, 0, 1); tick();
        checks++; if (s_sold_out !== 1'b0) begin failures++; $display("FAIL restock got=%b want=0", s_sold_out); end
`else
        checks++; if (s_sold_out !== 1'b0) begin failures++; $display("FAIL no_stock_sold_out got=%b want=0", s_sold_out); end
        drive(0, 1, 0, 1); tick();
        checks++; if (s_coin_reject !== 1'b0 || s_credit !== 3'd2 || s_sold_out !== 1'b0) begin failures++; $display("FAIL unlimited_stock got=%b/%0d/%b want=0/2/0", s_coin_reject, s_credit, s_sold_out); end
`endif
        drive(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_change();
        do_reset();
        drive(0, 1, 0, 0); tick(); tick();
        drive(1, 1, 0, 0); tick();
        drive(0, 0, 0, 0); tick();
        checks++; if (dispense !== 1'b1 || credit !== 5'd2 || busy !== 1'b1) begin failures++; $display("FAIL mid_setup got=%b/%0d/%b want=1/2/1", dispense, credit, busy); end
        #2 sys_rst_n = 1'b0;
        #1;
        checks++; if ({dispense, change_half, coin_reject, busy, credit} !== 9'b0) begin failures++; $display("FAIL mid_reset_async got=%b want=0", {dispense, change_half, coin_reject, busy, credit}); end
        #2 sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (change_half !== 1'b0 || busy !== 1'b0 || credit !== 5'd0) begin failures++; $display("FAIL mid_reset_quiet%0d got=%b/%b/%0d want=0/0/0", i, change_half, busy, credit); end
        end
    endtask

    initial begin
        test_reset();
        test_exact_vend();
        test_vend_change();
        test_cancel();
        test_reject_busy();
        test_cancel_wins();
        test_overflow_stock();
        test_reset_mid_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vend_ctrl_param.md
VEND_CTRL_PARAM -- requirements
Module: vend_ctrl_param

Interface
REQ-001 SHALL provide parameter PRICE, default 5, item price in half-unit (0.5) steps, legal range 1..2^CREDIT_W-1.
REQ-002 SHALL provide parameter CREDIT_W, default 5, width of the credit register in half-units.
REQ-003 SHALL provide parameter STOCK_W, default 4, width of the stock counter.
REQ-004 SHALL provide parameter STOCK_INIT, default 8, stock value loaded at reset and on restock.
REQ-005 SHALL provide the following ports; reset is sys_rst_n, asynchronous, active-low; clock is sys_clk:
  sys_clk  in  1  clock
  sys_rst_n  in  1  asynchronous active-low reset
  coin_half  in  1  one 0.5 coin per cycle high
  coin_one  in  1  one 1.0 coin per cycle high
  cancel  in  1  request refund of credit
  restock  in  1  reload stock (feature-gated)
  dispense  out  1  one-cycle vend pulse
  change_half  out  1  one pulse per 0.5 returned
  coin_reject  out  1  one-cycle pulse, coin returned unaccepted
  credit  out  CREDIT_W  current credit in half-units
  busy  out  1  high in VEND or CHANGE
  sold_out  out  1  stock empty (feature-gated)

Function
REQ-006 SHALL implement an FSM with states IDLE, VEND and CHANGE, all outputs registered.
REQ-007 In IDLE, the coin value for each cycle SHALL be computed as 1 per coin_half plus 2 per coin_one; both high in the same cycle SHALL add 3.
REQ-008 An accepted coin SHALL update credit at the same edge.
REQ-009 If credit+value >= PRICE, the FSM SHALL enter VEND at that edge.
REQ-010 If credit+value > 2^CREDIT_W-1, the coin(s) SHALL NOT be accepted, credit SHALL be unchanged and coin_reject SHALL pulse for 1 cycle.
REQ-011 In VEND, at the next edge: dispense SHALL be high for exactly 1 cycle, credit SHALL become credit-PRICE, and the next state SHALL be CHANGE if the remainder is >0, else IDLE.
REQ-012 In CHANGE, each edge SHALL pulse change_half and decrement credit by 1; the edge that takes credit to 0 SHALL return the FSM to IDLE.
REQ-013 The total number of change_half pulses SHALL equal the remainder.
REQ-014 Any coin while in VEND or CHANGE SHALL be rejected with a coin_reject pulse and SHALL NOT alter credit.
REQ-015 cancel in IDLE with credit>0 SHALL go to CHANGE without dispensing; cancel with credit==0 SHALL be ignored.
REQ-016 If cancel and a coin occur in the same IDLE cycle, cancel SHALL win, the coin SHALL be rejected, and the existing credit SHALL be refunded.
REQ-017 cancel in VEND or CHANGE SHALL be ignored.
REQ-018 busy SHALL equal (state != IDLE).
REQ-019 credit SHALL never wrap; underflow SHALL be impossible by construction.

Reset
REQ-020 Asserting sys_rst_n low SHALL immediately force state IDLE, credit 0, dispense/change_half/coin_reject/busy 0, and stock to STOCK_INIT.
REQ-021 Reset mid-VEND or mid-CHANGE SHALL abort and discard the remaining credit, with no further pulses.

Configuration
REQ-022 With macro VEND_STOCK_EN defined, a STOCK_W stock counter SHALL decrement on each dispense.
REQ-023 With VEND_STOCK_EN defined, sold_out SHALL be high when stock==0.
REQ-024 With VEND_STOCK_EN defined, while sold_out all coins SHALL be rejected; cancel SHALL still refund existing credit.
REQ-025 With VEND_STOCK_EN defined, restock (IDLE only) SHALL reload STOCK_INIT.
REQ-026 Without VEND_STOCK_EN, stock SHALL be unlimited, sold_out SHALL be tied 0, and restock SHALL be ignored.

Verification
REQ-027 PRICE=5: coin_one, coin_one, coin_half on consecutive cycles -> exactly one dispense pulse 1 cycle after the third coin; 0 change_half pulses; credit returns to 0; FSM back in IDLE.
REQ-028 PRICE=5: three coin_one -> dispense pulse, then 1 change_half pulse on the following cycle; credit returns to 0.
REQ-029 coin_one then coin_half then cancel -> 3 consecutive change_half pulses, no dispense, busy high for 3 cycles.
REQ-030 coin_one+coin_half together, then coin_one while in CHANGE after a vend -> credit 3 after the first; coin_reject pulse for the second; credit unaffected by the rejected coin.
REQ-031 VEND_STOCK_EN, STOCK_INIT=1: vend once -> sold_out=1; a following coin_one -> coin_reject; restock -> sold_out=0.
REQ-032 Reset asserted during CHANGE with 2 pulses remaining -> outputs 0 at once; no further change_half pulses after reset release.
